// File: rtl/sysid_check_master.sv
// rtl/sysid_check_master.sv - Avalon-MM read master that checks system ID and build timestamp (option: SYSID_CHECK_AUTOSTART_EN)
module sysid_check_master #(
   parameter logic [31:0] EXPECTED_ID    = 32'h12345678,
   parameter logic [31:0] EXPECTED_TS    = 32'h5CB5EAE4,
   parameter int          TIMEOUT_CYCLES = 256
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RD_ID = 2'd1,
      S_RD_TS = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   // Last stall count tolerated before a read is abandoned.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   logic        r_addr;
   logic        r_read;
   logic        r_busy;
   logic        r_done;
   logic        r_id_ok;
   logic        r_ts_ok;
   logic        r_timeout;
   logic [31:0] r_id_value;
   logic [31:0] r_ts_value;
   logic [15:0] r_cnt;
   logic        w_start;

`ifdef SYSID_CHECK_AUTOSTART_EN
   logic r_auto;

   // High for exactly the first cycle after reset releases: acts as an implicit start.
   always_ff @(posedge clock) begin
      if (reset) r_auto <= 1'b1;
      else       r_auto <= 1'b0;
   end

   assign w_start = start | r_auto;
`else
   assign w_start = start;
`endif

   // Sequencer: two back-to-back reads, compare, then report; all outputs registered.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_addr     <= 1'b0;
         r_read     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_id_ok    <= 1'b0;
         r_ts_ok    <= 1'b0;
         r_timeout  <= 1'b0;
         r_id_value <= 32'd0;
         r_ts_value <= 32'd0;
         r_cnt      <= 16'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state   <= S_RD_ID;
                  r_read    <= 1'b1;
                  r_addr    <= 1'b0;
                  r_busy    <= 1'b1;
                  r_done    <= 1'b0;
                  r_id_ok   <= 1'b0;
                  r_ts_ok   <= 1'b0;
                  r_timeout <= 1'b0;
                  r_cnt     <= 16'd0;
               end
            end
            S_RD_ID: begin
               if (!avm_waitrequest) begin
                  // Read stays asserted; only the address moves to the timestamp word.
                  r_id_value <= avm_readdata;
                  r_id_ok    <= (avm_readdata == EXPECTED_ID);
                  r_cnt      <= 16'd0;
                  r_addr     <= 1'b1;
                  r_state    <= S_RD_TS;
               end else if (r_cnt == TO_LAST) begin
                  r_read    <= 1'b0;
                  r_timeout <= 1'b1;
                  r_state   <= S_FIN;
               end else if (r_cnt != 16'hFFFF) begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_RD_TS: begin
               if (!avm_waitrequest) begin
                  r_ts_value <= avm_readdata;
                  r_ts_ok    <= (avm_readdata == EXPECTED_TS);
                  r_read     <= 1'b0;
                  r_state    <= S_FIN;
               end else if (r_cnt == TO_LAST) begin
                  r_read    <= 1'b0;
                  r_timeout <= 1'b1;
                  r_state   <= S_FIN;
               end else if (r_cnt != 16'hFFFF) begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_FIN: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign avm_address = r_addr;
   assign avm_read    = r_read;
   assign busy        = r_busy;
   assign done        = r_done;
   assign id_ok       = r_id_ok;
   assign ts_ok       = r_ts_ok;
   assign timeout     = r_timeout;
   assign id_value    = r_id_value;
   assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_sysid_check_master.sv
// tb/tb_sysid_check_master.sv - Self-checking bench for sysid_check_master against a behavioural slave and reference model
module tb_sysid_check_master;

   localparam logic [31:0] EXP_ID = 32'h12345678;
   localparam logic [31:0] EXP_TS = 32'h5CB5EAE4;
   localparam int          TO     = 8;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        busy, done, id_ok, ts_ok, timeout;
   logic [31:0] id_value, ts_value;

   int vectors = 0;
   int errs    = 0;

   // slave contents and stall programme
   logic [31:0] mem0 = EXP_ID;
   logic [31:0] mem1 = EXP_TS;
   int          sid  = 0;
   int          sts  = 0;
   int          scnt = 0;

   // reference model of the result registers persisting across runs
   logic [31:0] m_id_val = 32'd0;
   logic [31:0] m_ts_val = 32'd0;

   logic trace[$];

   sysid_check_master #(
      .EXPECTED_ID(EXP_ID),
      .EXPECTED_TS(EXP_TS),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock(clock),
      .reset(reset),
      .start(start),
      .avm_address(avm_address),
      .avm_read(avm_read),
      .avm_waitrequest(avm_waitrequest),
      .avm_readdata(avm_readdata),
      .busy(busy),
      .done(done),
      .id_ok(id_ok),
      .ts_ok(ts_ok),
      .timeout(timeout),
      .id_value(id_value),
      .ts_value(ts_value)
   );

   always #5 clock = ~clock;

   // behavioural slave: stalls a programmed number of cycles per address
   assign avm_waitrequest = avm_address ? (scnt < sts) : (scnt < sid);
   assign avm_readdata    = avm_address ? mem1 : mem0;

   always @(posedge clock) begin
      if (avm_read && avm_waitrequest) scnt <= scnt + 1;
      else                             scnt <= 0;
   end

   // bus monitor: one entry per cycle the read strobe is high
   always @(negedge clock) begin
      if (avm_read) trace.push_back(avm_address);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_read"},    32'(avm_read),    32'd0);
      check({tag, "_addr"},    32'(avm_address), 32'd0);
      check({tag, "_busy"},    32'(busy),        32'd0);
      check({tag, "_done"},    32'(done),        32'd0);
      check({tag, "_id_ok"},   32'(id_ok),       32'd0);
      check({tag, "_ts_ok"},   32'(ts_ok),       32'd0);
      check({tag, "_timeout"}, 32'(timeout),     32'd0);
      check({tag, "_id_val"},  id_value,         32'd0);
      check({tag, "_ts_val"},  ts_value,         32'd0);
   endtask

   // Runs one sequence and compares it with what the rules predict.
   task automatic run(input string tag, input logic [31:0] d_id, input logic [31:0] d_ts,
                      input int s_id, input int s_ts);
      int  n0, n1, k, bad;
      bit  to_exp, id_done, ts_done;
      @(negedge clock);
      mem0 = d_id; mem1 = d_ts; sid = s_id; sts = s_ts;
      trace.delete();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      id_done = (s_id < TO);
      ts_done = id_done && (s_ts < TO);
      to_exp  = !ts_done;
      n0 = id_done ? s_id + 1 : TO;
      n1 = !id_done ? 0 : (ts_done ? s_ts + 1 : TO);
      if (id_done) m_id_val = d_id;
      if (ts_done) m_ts_val = d_ts;
      k = 0;
      while (!done && k < 200) begin
         @(negedge clock);
         k++;
      end
      check({tag, "_latency"}, 32'(k), 32'(n0 + n1 + 1));
      bad = 0;
      for (int i = 0; i < trace.size(); i++)
         if (trace[i] !== ((i < n0) ? 1'b0 : 1'b1)) bad++;
      check({tag, "_trace_len"}, 32'(trace.size()), 32'(n0 + n1));
      check({tag, "_trace_addr"}, 32'(bad), 32'd0);
      check({tag, "_busy"},    32'(busy),    32'd0);
      check({tag, "_read"},    32'(avm_read), 32'd0);
      check({tag, "_id_ok"},   32'(id_ok),   32'(id_done && d_id == EXP_ID));
      check({tag, "_ts_ok"},   32'(ts_ok),   32'(ts_done && d_ts == EXP_TS));
      check({tag, "_timeout"}, 32'(timeout), 32'(to_exp));
      check({tag, "_id_val"},  id_value,     m_id_val);
      check({tag, "_ts_val"},  ts_value,     m_ts_val);
      @(negedge clock);
      check({tag, "_done_held"}, 32'(done), 32'd1);
   endtask

   // With the autostart option the design runs once after every reset release.
   task automatic post_reset(input string tag);
`ifdef SYSID_CHECK_AUTOSTART_EN
      int k;
      k = 0;
      while (!done && k < 200) begin
         @(negedge clock);
         k++;
      end
      m_id_val = mem0;
      m_ts_val = mem1;
      check({tag, "_auto_done"},  32'(done),  32'd1);
      check({tag, "_auto_id_ok"}, 32'(id_ok), 32'(mem0 == EXP_ID));
      check({tag, "_auto_ts_ok"}, 32'(ts_ok), 32'(mem1 == EXP_TS));
      check({tag, "_auto_id"},    id_value,   mem0);
`else
      repeat (3) @(negedge clock);
      check({tag, "_no_auto_busy"}, 32'(busy), 32'd0);
      check({tag, "_no_auto_done"}, 32'(done), 32'd0);
`endif
   endtask

   initial begin
      logic [31:0] rid, rts;
      int          a, b;

      // reset with start held: reset wins
      start = 1'b1;
      repeat (3) @(negedge clock);
      check_zero_outputs("reset");
      reset = 1'b0;
      start = 1'b0;
      post_reset("init");

      run("best",     EXP_ID,        EXP_TS, 0, 0);
      run("bad_id",   32'h12345679,  EXP_TS, 0, 0);
      run("stall5",   EXP_ID,        EXP_TS, 5, 5);
      run("to_ts",    EXP_ID,        EXP_TS, 0, 1000);
      run("to_id",    32'hDEADBEEF,  EXP_TS, 1000, 0);
      run("edge_ts",  EXP_ID,        EXP_TS, TO - 1, TO - 1);

      // restart ignored while busy, then reset during the timestamp read
      @(negedge clock);
      mem0 = EXP_ID; mem1 = EXP_TS; sid = 0; sts = 5;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("midrst_busy", 32'(busy),        32'd1);
      check("midrst_addr", 32'(avm_address), 32'd1);
      check("midrst_read", 32'(avm_read),    32'd1);
      reset = 1'b1;
      @(negedge clock);
      check_zero_outputs("midrst");
      reset = 1'b0;
      sts = 0;
      m_id_val = 32'd0;
      m_ts_val = 32'd0;
      post_reset("midrst");

      // randomized runs
      for (int i = 0; i < 20; i++) begin
         rid = ($urandom_range(0, 1) != 0) ? EXP_ID : $urandom;
         rts = ($urandom_range(0, 1) != 0) ? EXP_TS : $urandom;
         a   = $urandom_range(0, 10);
         b   = $urandom_range(0, 10);
         run($sformatf("rnd%0d", i), rid, rts, a, b);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
